// File: rtl/mul_arb_pkg.sv
// Shared constants for the multiplier arbiter: FSM encodings and watchdog sizing.
package mul_arb_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] BUSY  = 3'd2;
  localparam logic [2:0] RESP  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  localparam int TIMEOUT_DEF = 256;
  localparam int WD_W_DEF    = $clog2(TIMEOUT_DEF);

endpackage

// File: rtl/mul_arb_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      valid = valid | req[(int'(ptr) + i) % N_REQ];
      idx   = req[(int'(ptr) + i) % N_REQ] ? IW'((int'(ptr) + i) % N_REQ) : idx;
    end
  end

endmodule

// File: rtl/mul_arbiter_chk.sv
// Protocol checker: single-cycle start strobe and at most one response bit at a time.
module mul_arbiter_chk #(
  parameter int N_REQ = 2
) (
  input logic             Clk,
  input logic             rst,
  input logic             mul_st,
  input logic [N_REQ-1:0] resp_valid
);

  a_st_single: assert property (@(posedge Clk) disable iff (rst) mul_st |=> !mul_st);

  a_resp_onehot: assert property (@(posedge Clk) disable iff (rst) $onehot0(resp_valid));

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sequencer sharing one multiplier among N_REQ requesters, with a
// watchdog that aborts a multiplication whose Done never arrives.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     Clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_flat,
  input  logic [N_REQ*WIDTH-1:0]   b_flat,
  output logic [N_REQ-1:0]         resp_valid,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     resp_err,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] cur_id,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  output logic                     mul_st,
  input  logic                     mul_idle,
  input  logic                     mul_done,
  input  logic [WIDTH-1:0]         mul_prod
);

  localparam int IW   = $clog2(N_REQ);
  localparam int WD_W = $clog2(TIMEOUT);

  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT - 1);
  localparam logic [IW-1:0]    ID_LAST = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT = N_REQ'(1);

  logic [2:0]       state_r;
  logic [2:0]       state_nx_s;
  logic [IW-1:0]    ptr_r;
  logic [WD_W-1:0]  wd_r;
  logic             abort_r;
  logic [N_REQ-1:0] resp_valid_r;
  logic [WIDTH-1:0] resp_data_r;
  logic             resp_err_r;
  logic             busy_r;
  logic [IW-1:0]    cur_id_r;
  logic [WIDTH-1:0] mul_a_r;
  logic [WIDTH-1:0] mul_b_r;
  logic             mul_st_r;

  logic             pick_valid_s;
  logic [IW-1:0]    pick_idx_s;
  logic             grant_s;
  logic             cap_s;
  logic             abort_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  mul_arbiter_chk #(
    .N_REQ (N_REQ)
  ) u_chk (
    .Clk        (Clk),
    .rst        (rst),
    .mul_st     (mul_st_r),
    .resp_valid (resp_valid_r)
  );

  // Next-state decode plus the grant/capture/abort strobes for the datapath.
  always_comb begin
    state_nx_s = state_r;
    grant_s    = 1'b0;
    cap_s      = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s && mul_idle) begin
          grant_s    = 1'b1;
          state_nx_s = START;
        end else begin
          state_nx_s = IDLE;
        end
      end
      START: state_nx_s = BUSY;
      BUSY: begin
        if (mul_done) begin
          cap_s      = 1'b1;
          state_nx_s = RESP;
        end else if (wd_r == WD_MAX) begin
          abort_s    = 1'b1;
          state_nx_s = RESP;
        end else begin
          state_nx_s = BUSY;
        end
      end
      // An aborted multiplier may still be running; wait for it to go idle.
      RESP: begin
        if (abort_r) begin
          state_nx_s = DRAIN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      DRAIN: begin
        if (mul_idle) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, operand latch, watchdog, response and pointer registers.
  always_ff @(posedge Clk) begin
    if (rst) begin
      state_r      <= IDLE;
      ptr_r        <= '0;
      wd_r         <= '0;
      abort_r      <= 1'b0;
      resp_valid_r <= '0;
      resp_data_r  <= '0;
      resp_err_r   <= 1'b0;
      busy_r       <= 1'b0;
      cur_id_r     <= '0;
      mul_a_r      <= '0;
      mul_b_r      <= '0;
      mul_st_r     <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      busy_r   <= (state_nx_s != IDLE);
      mul_st_r <= grant_s;

      if (grant_s) begin
        mul_a_r  <= a_flat[int'(pick_idx_s)*WIDTH +: WIDTH];
        mul_b_r  <= b_flat[int'(pick_idx_s)*WIDTH +: WIDTH];
        cur_id_r <= pick_idx_s;
      end

      if (state_r == START) begin
        wd_r <= '0;
      end else if (state_r == BUSY && !mul_done && wd_r != WD_MAX) begin
        wd_r <= wd_r + WD_W'(1);
      end

      if (cap_s) begin
        resp_data_r <= mul_prod;
        resp_err_r  <= 1'b0;
        abort_r     <= 1'b0;
      end else if (abort_s) begin
        resp_data_r <= '0;
        resp_err_r  <= 1'b1;
        abort_r     <= 1'b1;
      end

      // The response pulse lines up with the RESP state.
      if (cap_s || abort_s) begin
        resp_valid_r <= ONE_HOT << cur_id_r;
      end else begin
        resp_valid_r <= '0;
      end

      if (state_r == RESP) begin
        ptr_r <= (cur_id_r == ID_LAST) ? '0 : cur_id_r + IW'(1);
      end
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_err   = resp_err_r;
  assign busy       = busy_r;
  assign cur_id     = cur_id_r;
  assign mul_a      = mul_a_r;
  assign mul_b      = mul_b_r;
  assign mul_st     = mul_st_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with two requesters and a behavioural
// multiplier that can be made to hang.
module tb_mul_arbiter;

  localparam int N       = 2;
  localparam int W       = 32;
  localparam int TMO     = 256;
  localparam int MUL_LAT = 6;

  logic           Clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_flat;
  logic [N*W-1:0] b_flat;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic           busy;
  logic [0:0]     cur_id;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_st;
  logic           mul_idle;
  logic           mul_done;
  logic [W-1:0]   mul_prod;

  logic           stuck_mode;
  logic           m_run;
  logic [W-1:0]   m_res;
  int             m_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         id;
    logic [31:0] data;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   grant_q[$];
  int   resp_cnt[N];

  mul_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TMO)) dut (
    .Clk        (Clk),
    .rst        (rst),
    .req        (req),
    .a_flat     (a_flat),
    .b_flat     (b_flat),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy),
    .cur_id     (cur_id),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_st     (mul_st),
    .mul_idle   (mul_idle),
    .mul_done   (mul_done),
    .mul_prod   (mul_prod)
  );

  always #5 Clk = ~Clk;

  // Multiplier stand-in: fixed latency, Done pulse with Idle rising; freezes while stuck_mode.
  always @(posedge Clk) begin
    if (rst) begin
      mul_idle <= 1'b1;
      mul_done <= 1'b0;
      mul_prod <= '0;
      m_run    <= 1'b0;
      m_res    <= '0;
      m_cnt    <= 0;
    end else begin
      mul_done <= 1'b0;
      if (m_run) begin
        if (!stuck_mode) begin
          if (m_cnt == 0) begin
            mul_done <= 1'b1;
            mul_prod <= m_res;
            mul_idle <= 1'b1;
            m_run    <= 1'b0;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
      end else if (mul_st && mul_idle) begin
        m_res    <= mul_a * mul_b;
        m_run    <= 1'b1;
        mul_idle <= 1'b0;
        m_cnt    <= MUL_LAT;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_resp(input int id, input logic [31:0] data, input logic err);
    exp_t e;
    e.id   = id;
    e.data = data;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    a_flat[i*W +: W] = a;
    b_flat[i*W +: W] = b;
  endtask

  // Watches the DUT every falling edge: start-strobe spacing, grant order, responses.
  task automatic monitor();
    logic prev_st;
    exp_t e;
    prev_st = 1'b0;
    forever begin
      @(negedge Clk);
      if (rst) begin
        prev_st = 1'b0;
      end else begin
        if (mul_st) begin
          check_eq("st_gap", 32'(prev_st), 32'd0);
          grant_q.push_back(int'(cur_id));
        end
        prev_st = mul_st;
        if (|resp_valid) begin
          for (int i = 0; i < N; i++) if (resp_valid[i]) resp_cnt[i]++;
          if (sb_q.size() == 0) begin
            check_eq("resp_unexp", 32'(resp_valid), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check_eq("resp_id", 32'(resp_valid), 32'd1 << e.id);
            check_eq("resp_data", resp_data, e.data);
            check_eq("resp_err", 32'(resp_err), 32'(e.err));
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    rst = 1'b1;
    repeat (2) @(negedge Clk);
    rst = 1'b0;
  endtask

  task automatic wait_st();
    int k;
    k = 0;
    while (!mul_st && k < 500) begin
      @(negedge Clk);
      k++;
    end
    check_eq("st_wait", 32'(mul_st), 32'd1);
  endtask

  task automatic wait_resp(input int id);
    int k;
    k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (!resp_valid[id] && k < 500);
    check_eq("resp_wait", 32'(resp_valid[id]), 32'd1);
    req[id] = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    int lat;
    int g;
    int r1c;
    rst        = 1'b1;
    req        = '0;
    a_flat     = '0;
    b_flat     = '0;
    stuck_mode = 1'b0;
    for (int i = 0; i < N; i++) resp_cnt[i] = 0;
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(negedge Clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_data", resp_data, 32'd0);
    check_eq("rst_err", 32'(resp_err), 32'd0);
    check_eq("rst_cur_id", 32'(cur_id), 32'd0);
    check_eq("rst_mul_a", mul_a, 32'd0);
    check_eq("rst_mul_b", mul_b, 32'd0);
    check_eq("rst_mul_st", 32'(mul_st), 32'd0);
    rst = 1'b0;

    // 1: single request, latency from grant and from Done
    @(negedge Clk);
    set_op(0, 32'hA5, 32'h14);
    expect_resp(0, 32'd3300, 1'b0);
    req[0] = 1'b1;
    @(negedge Clk);
    check_eq("t1_st", 32'(mul_st), 32'd1);
    check_eq("t1_mul_a", mul_a, 32'hA5);
    check_eq("t1_mul_b", mul_b, 32'h14);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_cur_id", 32'(cur_id), 32'd0);
    @(negedge Clk);
    check_eq("t1_st_low", 32'(mul_st), 32'd0);
    k = 0;
    while (!mul_done && k < 100) begin
      @(negedge Clk);
      k++;
    end
    check_eq("t1_done_wait", 32'(mul_done), 32'd1);
    @(negedge Clk);
    check_eq("t1_resp_lat", 32'(resp_valid), 32'd1);
    req[0] = 1'b0;
    repeat (3) @(negedge Clk);
    check_eq("t1_idle", 32'(busy), 32'd0);

    // 2: simultaneous requests from a fresh pointer
    do_reset();
    set_op(0, 32'h12345678, 32'h2);
    set_op(1, 32'hFFFFFFFF, 32'hFF);
    expect_resp(0, 32'h2468ACF0, 1'b0);
    expect_resp(1, 32'hFFFFFF01, 1'b0);
    req = 2'b11;
    wait_resp(0);
    wait_resp(1);

    // 3: both held through four services
    repeat (2) @(negedge Clk);
    grant_q.delete();
    set_op(0, 32'd3, 32'd5);
    set_op(1, 32'd7, 32'd9);
    for (int i = 0; i < 4; i++) expect_resp(i % 2, (i % 2 == 0) ? 32'd15 : 32'd63, 1'b0);
    req = 2'b11;
    n = 0;
    k = 0;
    while (n < 4 && k < 600) begin
      @(negedge Clk);
      k++;
      if (|resp_valid) n++;
    end
    req = 2'b00;
    check_eq("t3_count", 32'(n), 32'd4);
    check_eq("t3_grants", 32'(grant_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq("t3_order", (i < grant_q.size()) ? 32'(grant_q[i]) : 32'hFFFFFFFF, 32'(i % 2));

    // 4: hung multiplier -> abort, then drain before the next grant
    repeat (2) @(negedge Clk);
    stuck_mode = 1'b1;
    set_op(0, 32'd5, 32'd5);
    expect_resp(0, 32'd0, 1'b1);
    req[0] = 1'b1;
    wait_st();
    lat = 0;
    while (!resp_valid[0] && lat < 400) begin
      @(negedge Clk);
      lat++;
    end
    req[0] = 1'b0;
    check_eq("t4_tmo_lat", 32'(lat >= TMO && lat <= TMO + 1), 32'd1);
    g = grant_q.size();
    set_op(1, 32'd11, 32'd13);
    expect_resp(1, 32'd143, 1'b0);
    req[1] = 1'b1;
    repeat (5) @(negedge Clk);
    check_eq("t4_drain_busy", 32'(busy), 32'd1);
    check_eq("t4_drain_nogrant", 32'(grant_q.size()), 32'(g));
    stuck_mode = 1'b0;
    wait_resp(1);

    // 5: reset during BUSY, then a clean request
    repeat (2) @(negedge Clk);
    set_op(0, 32'd9, 32'd9);
    req[0] = 1'b1;
    wait_st();
    repeat (3) @(negedge Clk);
    rst    = 1'b1;
    req[0] = 1'b0;
    @(posedge Clk);
    #1;
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_valid", 32'(resp_valid), 32'd0);
    check_eq("t5_st", 32'(mul_st), 32'd0);
    @(negedge Clk);
    rst = 1'b0;
    repeat (20) @(negedge Clk);
    set_op(0, 32'd6, 32'd7);
    expect_resp(0, 32'd42, 1'b0);
    req[0] = 1'b1;
    wait_resp(0);

    // 6: requester 1 withdraws before it is granted
    repeat (2) @(negedge Clk);
    set_op(0, 32'd100, 32'd3);
    expect_resp(0, 32'd300, 1'b0);
    req[0] = 1'b1;
    wait_st();
    @(negedge Clk);
    g   = grant_q.size();
    r1c = resp_cnt[1];
    req[1] = 1'b1;
    repeat (2) @(negedge Clk);
    req[1] = 1'b0;
    wait_resp(0);
    repeat (10) @(negedge Clk);
    check_eq("t6_nogrant", 32'(grant_q.size()), 32'(g));
    check_eq("t6_noresp", 32'(resp_cnt[1]), 32'(r1c));
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
